// File: rtl/n64_sdram_arb_pkg.sv
// Shared types and constants for the three-requester SDRAM arbiter.
package n64_sdram_arb_pkg;

    localparam int ADDR_W          = 27;
    localparam int DATA_W          = 32;
    localparam int BE_W            = 4;
    localparam int NUM_REQ         = 3;
    localparam int TIMEOUT_DEFAULT = 4096;

    localparam logic [1:0] REQ_DL   = 2'd0;
    localparam logic [1:0] REQ_CART = 2'd1;
    localparam logic [1:0] REQ_SAVE = 2'd2;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ISSUE = 2'd1,
        ST_WAIT  = 2'd2
    } arb_state_t;

    typedef struct packed {
        logic              rnw;
        logic [ADDR_W-1:0] addr;
        logic [BE_W-1:0]   be;
        logic [DATA_W-1:0] din;
    } slot_t;

    // Download wins outright; cart and save alternate, last_rr remembers which of the two went last.
    function automatic logic [1:0] pick_grant(input logic [NUM_REQ-1:0] pend,
                                              input logic [1:0]         last_rr);
        logic [1:0] g;
        g = REQ_SAVE;
        if (pend[REQ_DL])
            g = REQ_DL;
        else if (pend[REQ_CART] && pend[REQ_SAVE])
            g = (last_rr == REQ_CART) ? REQ_SAVE : REQ_CART;
        else if (pend[REQ_CART])
            g = REQ_CART;
        return g;
    endfunction

endpackage

// File: rtl/sdram_arbiter_if.sv
// Requester and SDRAM-channel signals of the arbiter; slave = arbiter, master = environment.
interface sdram_arbiter_if;
    import n64_sdram_arb_pkg::*;

    logic [NUM_REQ-1:0]             req_ena;
    logic [NUM_REQ-1:0]             req_rnw;
    logic [NUM_REQ-1:0][ADDR_W-1:0] req_addr;
    logic [NUM_REQ-1:0][BE_W-1:0]   req_be;
    logic [NUM_REQ-1:0][DATA_W-1:0] req_din;
    logic [NUM_REQ-1:0]             req_done;
    logic [DATA_W-1:0]              req_dout;

    logic                           sdram_ena;
    logic                           sdram_rnw;
    logic [ADDR_W-1:0]              sdram_Adr;
    logic [BE_W-1:0]                sdram_be;
    logic [DATA_W-1:0]              sdram_dataWrite;
    logic                           sdram_done;
    logic [DATA_W-1:0]              sdram_dataRead;

    logic                           timeout_err;
    logic                           busy;

    modport slave (
        input  req_ena, req_rnw, req_addr, req_be, req_din, sdram_done, sdram_dataRead,
        output req_done, req_dout, sdram_ena, sdram_rnw, sdram_Adr, sdram_be,
               sdram_dataWrite, timeout_err, busy
    );

    modport master (
        output req_ena, req_rnw, req_addr, req_be, req_din, sdram_done, sdram_dataRead,
        input  req_done, req_dout, sdram_ena, sdram_rnw, sdram_Adr, sdram_be,
               sdram_dataWrite, timeout_err, busy
    );

endinterface

// File: rtl/sdram_arb_slot.sv
// One requester slot: pending flag plus captured command, a new request beats a same-edge clear.
// Latency: captured on the edge that samples set_req; repeats while pending (and not clearing) are dropped.
module sdram_arb_slot
    import n64_sdram_arb_pkg::*;
(
    input  logic  clk1x,
    input  logic  reset_n,
    input  logic  set_req,
    input  slot_t set_dat,
    input  logic  clr,
    output logic  pend,
    output slot_t slot
);

    always_ff @(posedge clk1x or negedge reset_n) begin
        if (!reset_n) begin
            pend <= 1'b0;
            slot <= '0;
        end else if (set_req && (!pend || clr)) begin
            pend <= 1'b1;
            slot <= set_dat;
        end else if (clr) begin
            pend <= 1'b0;
        end
    end

endmodule

// File: rtl/sdram_arbiter.sv
// Three-way SDRAM arbiter: download has strict priority, cart/save round-robin, one access in flight.
// Latency: request to sdram_ena is 2 cycles, sdram_done to req_done 1 cycle; WAIT force-completes after TIMEOUT_CYCLES.
module sdram_arbiter
    import n64_sdram_arb_pkg::*;
#(
    parameter int TIMEOUT_CYCLES = TIMEOUT_DEFAULT
) (
    input  logic           clk1x,
    input  logic           reset_n,
    sdram_arbiter_if.slave bus
);

    localparam logic [15:0] TO_LAST = 16'(TIMEOUT_CYCLES - 1);

    logic [NUM_REQ-1:0] pend;
    logic [NUM_REQ-1:0] clr;
    slot_t              slot_q [NUM_REQ];

    for (genvar i = 0; i < NUM_REQ; i++) begin : g_slot
        slot_t set_dat;
        assign set_dat = '{rnw:  bus.req_rnw[i],
                           addr: bus.req_addr[i],
                           be:   bus.req_be[i],
                           din:  bus.req_din[i]};

        sdram_arb_slot u_slot (
            .clk1x   (clk1x),
            .reset_n (reset_n),
            .set_req (bus.req_ena[i]),
            .set_dat (set_dat),
            .clr     (clr[i]),
            .pend    (pend[i]),
            .slot    (slot_q[i])
        );
    end

    arb_state_t         state;
    logic [1:0]         grant;
    logic [1:0]         last_rr;
    logic [15:0]        wait_cnt;
    logic [NUM_REQ-1:0] done_r;
    logic [DATA_W-1:0]  dout_r;
    logic               ena_r;
    logic               to_r;
    slot_t              cmd_r;

    logic [1:0]         grant_nxt;
    logic               done_now;
    logic               to_now;
    logic               finish;

    always_comb begin
        grant_nxt = pick_grant(pend, last_rr);
        done_now  = (state == ST_WAIT) && bus.sdram_done;
        to_now    = (state == ST_WAIT) && !bus.sdram_done && (wait_cnt == TO_LAST);
        finish    = done_now || to_now;
        clr       = '0;
        if (finish)
            clr[grant] = 1'b1;
    end

    always_ff @(posedge clk1x or negedge reset_n) begin
        if (!reset_n) begin
            state    <= ST_IDLE;
            grant    <= REQ_DL;
            last_rr  <= REQ_SAVE;
            wait_cnt <= '0;
            done_r   <= '0;
            dout_r   <= '0;
            ena_r    <= 1'b0;
            to_r     <= 1'b0;
            cmd_r    <= '0;
        end else begin
            done_r <= '0;
            ena_r  <= 1'b0;
            to_r   <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (|pend) begin
                        grant <= grant_nxt;
                        cmd_r <= slot_q[grant_nxt];
                        ena_r <= 1'b1;
                        state <= ST_ISSUE;
                    end
                end
                ST_ISSUE: begin
                    wait_cnt <= '0;
                    state    <= ST_WAIT;
                end
                ST_WAIT: begin
                    if (finish) begin
                        done_r   <= NUM_REQ'(1) << grant;
                        dout_r   <= done_now ? bus.sdram_dataRead : '0;
                        to_r     <= to_now;
                        // Download grants leave the cart/save rotation where it was.
                        if (grant != REQ_DL)
                            last_rr <= grant;
                        wait_cnt <= '0;
                        state    <= ST_IDLE;
                    end else begin
                        wait_cnt <= wait_cnt + 16'd1;
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

    assign bus.req_done        = done_r;
    assign bus.req_dout        = dout_r;
    assign bus.sdram_ena       = ena_r;
    assign bus.sdram_rnw       = cmd_r.rnw;
    assign bus.sdram_Adr       = cmd_r.addr;
    assign bus.sdram_be        = cmd_r.be;
    assign bus.sdram_dataWrite = cmd_r.din;
    assign bus.timeout_err     = to_r;
    assign bus.busy            = (state != ST_IDLE) || (|pend);

endmodule
